// File: rtl/hazard_scoreboard.sv
//------------------------------------------------------------------------------
// hazard_scoreboard: forwarding selects, load-use/scoreboard stall and a busy
// register scoreboard for multi-cycle ops. Optional macro: HAZARD_PERF_CNT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_scoreboard #(
  parameter int REG_ADDR_W      = 5,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PERF_W          = 32
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [REG_ADDR_W-1:0]                    id_rs1_addr,
  input  logic [REG_ADDR_W-1:0]                    id_rs2_addr,
  input  logic [REG_ADDR_W-1:0]                    id_rd_addr,
  input  logic                                     id_rs1_used,
  input  logic                                     id_rs2_used,
  input  logic                                     id_reg_write_en,
  input  logic [REG_ADDR_W-1:0]                    id_ex_r_rs1_addr,
  input  logic [REG_ADDR_W-1:0]                    id_ex_r_rs2_addr,
  input  logic [REG_ADDR_W-1:0]                    id_ex_r_rd_addr,
  input  logic                                     id_ex_r_mem_read,
  input  logic [REG_ADDR_W-1:0]                    ex_mem_r_rd_addr,
  input  logic                                     ex_mem_r_reg_write_en,
  input  logic [REG_ADDR_W-1:0]                    mem_wb_r_rd_addr,
  input  logic                                     mem_wb_r_reg_write_en,
  input  logic                                     mdu_issue_valid,
  input  logic [REG_ADDR_W-1:0]                    mdu_issue_rd,
  output logic                                     mdu_issue_ready,
  input  logic                                     mdu_done,
  input  logic [REG_ADDR_W-1:0]                    mdu_done_rd,
  input  logic                                     mdu_kill,
  output logic [1:0]                               forward_a_select,
  output logic [1:0]                               forward_b_select,
  output logic                                     stall_id,
  output logic [2**REG_ADDR_W-1:0]                 busy_vec,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_cnt
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]                        stall_cycles
`endif
);

  localparam int                    NUM_REGS = 2**REG_ADDR_W;
  localparam int                    CNT_W    = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_issue_acc;
  logic                w_done_eff;
  logic                w_load_use;
  logic                w_busy_raw;
  logic                w_busy_waw;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] exm_rd,
    input logic                  exm_we,
    input logic [REG_ADDR_W-1:0] mwb_rd,
    input logic                  mwb_we
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (exm_we && (exm_rd != ZERO_REG) && (exm_rd == src)) begin
      sel = 2'b01;
    end else if (mwb_we && (mwb_rd != ZERO_REG) && (mwb_rd == src)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    forward_a_select = fwd_sel(id_ex_r_rs1_addr, ex_mem_r_rd_addr, ex_mem_r_reg_write_en,
                               mem_wb_r_rd_addr, mem_wb_r_reg_write_en);
    forward_b_select = fwd_sel(id_ex_r_rs2_addr, ex_mem_r_rd_addr, ex_mem_r_reg_write_en,
                               mem_wb_r_rd_addr, mem_wb_r_reg_write_en);
  end

  assign w_load_use = id_ex_r_mem_read && (id_ex_r_rd_addr != ZERO_REG) &&
                      ((id_rs1_used && (id_rs1_addr == id_ex_r_rd_addr)) ||
                       (id_rs2_used && (id_rs2_addr == id_ex_r_rd_addr)));
  assign w_busy_raw = (id_rs1_used && (id_rs1_addr != ZERO_REG) && r_busy[id_rs1_addr]) ||
                      (id_rs2_used && (id_rs2_addr != ZERO_REG) && r_busy[id_rs2_addr]);
  assign w_busy_waw = id_reg_write_en && (id_rd_addr != ZERO_REG) && r_busy[id_rd_addr];
  assign stall_id   = w_load_use || w_busy_raw || w_busy_waw;

  // Ready looks only at registered state so a same-cycle done never frees a slot early.
  assign mdu_issue_ready = (r_cnt < CNT_MAX) && !r_busy[mdu_issue_rd];
  assign w_issue_acc     = mdu_issue_valid && mdu_issue_ready && (mdu_issue_rd != ZERO_REG);
  assign w_done_eff      = mdu_done && (mdu_done_rd != ZERO_REG) && r_busy[mdu_done_rd];

  always_comb begin
    w_busy_nxt = r_busy;
    w_cnt_nxt  = r_cnt;
    if (mdu_kill) begin
      w_busy_nxt = '0;
      w_cnt_nxt  = '0;
    end else begin
      // An accepted issue targets a non-busy rd and a done a busy one, so they never collide.
      if (w_done_eff) begin
        w_busy_nxt[mdu_done_rd] = 1'b0;
      end
      if (w_issue_acc) begin
        w_busy_nxt[mdu_issue_rd] = 1'b1;
      end
      case ({w_issue_acc, w_done_eff})
        2'b10: if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + CNT_W'(1);
        2'b01: if (r_cnt != '0)      w_cnt_nxt = r_cnt - CNT_W'(1);
        default: w_cnt_nxt = r_cnt;
      endcase
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign busy_vec        = r_busy;
  assign outstanding_cnt = r_cnt;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (stall_id && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  // PERF_W stays in the parameter list so both builds share one parameter set.
  if (PERF_W > 0) begin : g_no_perf_cnt
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios then random traffic against a
// queue-based model of the outstanding multi-cycle ops.
`default_nettype none

module tb_hazard_scoreboard;
  localparam int AW   = 5;
  localparam int MAXO = 4;
  localparam int PW   = 32;
  localparam int NR   = 32;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic          id_rs1_used, id_rs2_used, id_reg_write_en;
  logic [AW-1:0] id_ex_r_rs1_addr, id_ex_r_rs2_addr, id_ex_r_rd_addr;
  logic          id_ex_r_mem_read;
  logic [AW-1:0] ex_mem_r_rd_addr, mem_wb_r_rd_addr;
  logic          ex_mem_r_reg_write_en, mem_wb_r_reg_write_en;
  logic          mdu_issue_valid, mdu_issue_ready, mdu_done, mdu_kill;
  logic [AW-1:0] mdu_issue_rd, mdu_done_rd;
  logic [1:0]    forward_a_select, forward_b_select;
  logic          stall_id;
  logic [NR-1:0] busy_vec;
  logic [CW-1:0] outstanding_cnt;
`ifdef HAZARD_PERF_CNT_EN
  logic [PW-1:0] stall_cycles;
`endif

  int            total = 0;
  int            bad   = 0;
  int            q[$];
  logic [PW-1:0] perf_m = '0;
  logic [PW-1:0] perf_snap;

  hazard_scoreboard #(.REG_ADDR_W(AW), .MAX_OUTSTANDING(MAXO), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_reg_write_en(id_reg_write_en),
    .id_ex_r_rs1_addr(id_ex_r_rs1_addr), .id_ex_r_rs2_addr(id_ex_r_rs2_addr),
    .id_ex_r_rd_addr(id_ex_r_rd_addr), .id_ex_r_mem_read(id_ex_r_mem_read),
    .ex_mem_r_rd_addr(ex_mem_r_rd_addr), .ex_mem_r_reg_write_en(ex_mem_r_reg_write_en),
    .mem_wb_r_rd_addr(mem_wb_r_rd_addr), .mem_wb_r_reg_write_en(mem_wb_r_reg_write_en),
    .mdu_issue_valid(mdu_issue_valid), .mdu_issue_rd(mdu_issue_rd),
    .mdu_issue_ready(mdu_issue_ready), .mdu_done(mdu_done), .mdu_done_rd(mdu_done_rd),
    .mdu_kill(mdu_kill), .forward_a_select(forward_a_select),
    .forward_b_select(forward_b_select), .stall_id(stall_id), .busy_vec(busy_vec),
    .outstanding_cnt(outstanding_cnt)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic bit is_busy(int r);
    if (r == 0) return 1'b0;
    foreach (q[i]) if (q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NR-1:0] busy_model();
    logic [NR-1:0] v;
    v = '0;
    foreach (q[i]) v[q[i]] = 1'b1;
    return v;
  endfunction

  function automatic logic [1:0] fwd_model(int src, int xr, bit xw, int wr, bit ww);
    if (xw && xr != 0 && xr == src) return 2'd1;
    if (ww && wr != 0 && wr == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {id_rs1_addr, id_rs2_addr, id_rd_addr} = '0;
    {id_rs1_used, id_rs2_used, id_reg_write_en} = '0;
    {id_ex_r_rs1_addr, id_ex_r_rs2_addr, id_ex_r_rd_addr, id_ex_r_mem_read} = '0;
    {ex_mem_r_rd_addr, ex_mem_r_reg_write_en, mem_wb_r_rd_addr, mem_wb_r_reg_write_en} = '0;
    {mdu_issue_valid, mdu_issue_rd, mdu_done, mdu_done_rd, mdu_kill} = '0;
  endtask

  // Called at posedge+1 with inputs driven; checks combinational outputs,
  // advances the model across the next edge, then checks registered state.
  task automatic step();
    bit exp_stall, exp_ready, ia, de;
    #2;
    exp_stall = (id_ex_r_mem_read && id_ex_r_rd_addr != 0 &&
                 ((id_rs1_used && id_rs1_addr == id_ex_r_rd_addr) ||
                  (id_rs2_used && id_rs2_addr == id_ex_r_rd_addr))) ||
                (id_rs1_used && is_busy(int'(id_rs1_addr))) ||
                (id_rs2_used && is_busy(int'(id_rs2_addr))) ||
                (id_reg_write_en && is_busy(int'(id_rd_addr)));
    exp_ready = (q.size() < MAXO) && !is_busy(int'(mdu_issue_rd));
    chk("fwd_a", forward_a_select, fwd_model(int'(id_ex_r_rs1_addr), int'(ex_mem_r_rd_addr),
        ex_mem_r_reg_write_en, int'(mem_wb_r_rd_addr), mem_wb_r_reg_write_en));
    chk("fwd_b", forward_b_select, fwd_model(int'(id_ex_r_rs2_addr), int'(ex_mem_r_rd_addr),
        ex_mem_r_reg_write_en, int'(mem_wb_r_rd_addr), mem_wb_r_reg_write_en));
    chk("stall_id", stall_id, exp_stall);
    chk("issue_ready", mdu_issue_ready, exp_ready);
    if (mdu_kill) begin
      q.delete();
    end else begin
      de = mdu_done && is_busy(int'(mdu_done_rd));
      ia = mdu_issue_valid && exp_ready && mdu_issue_rd != 0;
      if (de) begin
        for (int i = 0; i < q.size(); i++) if (q[i] == int'(mdu_done_rd)) begin q.delete(i); break; end
      end
      if (ia) q.push_back(int'(mdu_issue_rd));
    end
    if (exp_stall && perf_m != '1) perf_m++;
    @(posedge clk);
    #1;
    chk("busy_vec", busy_vec, busy_model());
    chk("count", outstanding_cnt, q.size());
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, perf_m);
`endif
  endtask

  task automatic issue(int rd);
    idle();
    mdu_issue_valid = 1'b1;
    mdu_issue_rd = AW'(rd);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst_busy", busy_vec, 0);
    chk("rst_count", outstanding_cnt, 0);
    chk("rst_ready", mdu_issue_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Forwarding priority and register-0 exclusion
    idle();
    ex_mem_r_rd_addr = 5; ex_mem_r_reg_write_en = 1;
    mem_wb_r_rd_addr = 5; mem_wb_r_reg_write_en = 1;
    id_ex_r_rs1_addr = 5;
    step();
    chk("fwd_exmem_wins", forward_a_select, 2'b01);
    ex_mem_r_rd_addr = 0;
    step();
    chk("fwd_memwb_only", forward_a_select, 2'b10);
    mem_wb_r_rd_addr = 0;
    step();
    chk("fwd_rd0", forward_a_select, 2'b00);
    ex_mem_r_rd_addr = 6; ex_mem_r_reg_write_en = 0; id_ex_r_rs2_addr = 6;
    step();

    // Load-use
    idle();
    id_ex_r_mem_read = 1; id_ex_r_rd_addr = 7; id_rs2_addr = 7; id_rs2_used = 1;
    step();
    chk("load_use", stall_id, 1);
    id_rs2_used = 0;
    step();
    chk("load_use_unused", stall_id, 0);

    // Issue 3, 3 (WAW reject), 9, 10, then 11 fills the table
    issue(3);
    idle(); mdu_issue_valid = 1; mdu_issue_rd = 3;
    #2 chk("waw_reject_ready", mdu_issue_ready, 0);
    #(-0) step();
    issue(9);
    issue(10);
    chk("count_3", outstanding_cnt, 3);
    issue(11);
    chk("count_4", outstanding_cnt, 4);
    idle(); mdu_issue_rd = 20;
    #2 chk("full_ready", mdu_issue_ready, 0);
    step();
    issue(0);
    idle(); mdu_kill = 1; mdu_issue_valid = 1; mdu_issue_rd = 0; mdu_done = 1; mdu_done_rd = 3;
    step();

    // Simultaneous done and issue
    issue(3);
    issue(9);
    idle(); mdu_done = 1; mdu_done_rd = 3; mdu_issue_valid = 1; mdu_issue_rd = 12;
    step();
    chk("swap_busy", busy_vec, 32'h0000_1200);
    chk("swap_count", outstanding_cnt, 2);
    idle(); mdu_done = 1; mdu_done_rd = 4;
    step();

    // RAW stall on a busy register, then kill
    idle(); mdu_kill = 1;
    step();
    issue(3);
    issue(9);
    perf_snap = perf_m;
    idle(); id_rs1_addr = 9; id_rs1_used = 1;
    repeat (4) begin
      step();
      chk("raw_stall", stall_id, 1);
    end
    idle(); mdu_kill = 1; mdu_issue_valid = 1; mdu_issue_rd = 15;
    step();
    chk("kill_busy", busy_vec, 0);
    chk("kill_count", outstanding_cnt, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_delta", stall_cycles - perf_snap, 4);
`endif

    // Asynchronous reset mid-operation
    issue(3);
    issue(9);
    chk("pre_reset_count", outstanding_cnt, 2);
    idle(); mdu_issue_rd = 3;
    ex_mem_r_rd_addr = 5; ex_mem_r_reg_write_en = 1; id_ex_r_rs1_addr = 5;
    #3 rst_n = 1'b0;
    #1;
    chk("async_busy", busy_vec, 0);
    chk("async_count", outstanding_cnt, 0);
    chk("async_ready", mdu_issue_ready, 1);
    chk("async_fwd", forward_a_select, 2'b01);
`ifdef HAZARD_PERF_CNT_EN
    chk("async_perf", stall_cycles, 0);
`endif
    q.delete();
    perf_m = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(4);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      id_rs1_addr = AW'($urandom_range(0, 7));
      id_rs2_addr = AW'($urandom_range(0, 7));
      id_rd_addr = AW'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      id_reg_write_en = 1'($urandom_range(0, 1));
      id_ex_r_rs1_addr = AW'($urandom_range(0, 7));
      id_ex_r_rs2_addr = AW'($urandom_range(0, 7));
      id_ex_r_rd_addr = AW'($urandom_range(0, 7));
      id_ex_r_mem_read = ($urandom_range(0, 3) == 0);
      ex_mem_r_rd_addr = AW'($urandom_range(0, 7));
      ex_mem_r_reg_write_en = 1'($urandom_range(0, 1));
      mem_wb_r_rd_addr = AW'($urandom_range(0, 7));
      mem_wb_r_reg_write_en = 1'($urandom_range(0, 1));
      mdu_issue_valid = 1'($urandom_range(0, 1));
      mdu_issue_rd = AW'($urandom_range(0, 7));
      mdu_done = ($urandom_range(0, 2) == 0);
      if (q.size() > 0 && $urandom_range(0, 1) == 1)
        mdu_done_rd = AW'(q[$urandom_range(0, q.size() - 1)]);
      else
        mdu_done_rd = AW'($urandom_range(0, 7));
      mdu_kill = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
